// File: rtl/breakout_game_ctrl_if.sv
// Breakout controller bus: engine/keypad inputs and game status outputs.
// slave = controller side, master = side that drives events and reads status.
interface breakout_game_ctrl_if;
    logic        frame_tick;
    logic        key_ready;
    logic [4:0]  key_code;
    logic        hit;
    logic        miss;
    logic [1:0]  state;
    logic        gra_still;
    logic [1:0]  balls;
    logic [15:0] score;
    logic        game_over;

    modport master (
        output frame_tick, key_ready, key_code, hit, miss,
        input  state, gra_still, balls, score, game_over
    );

    modport slave (
        input  frame_tick, key_ready, key_code, hit, miss,
        output state, gra_still, balls, score, game_over
    );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: newgame/play/newball/over FSM, ball count, BCD score.
// Ports: clk, reset (sync, active-high), bus (slave: events in, status out).
module breakout_game_ctrl #(
    parameter int         BALLS        = 3,
    parameter int         DELAY_FRAMES = 120,
    parameter logic [4:0] START_KEY    = 5'h10
) (
    input  logic                 clk,
    input  logic                 reset,
    breakout_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_NEWGAME = 2'b00,
        S_PLAY    = 2'b01,
        S_NEWBALL = 2'b10,
        S_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [7:0] DELAY_INIT = 8'(DELAY_FRAMES);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  balls_q, balls_d;
    logic [15:0] score_q, score_d;
    logic        still_q, still_d;
    logic        over_q, over_d;
    logic        key_ready_d;
    logic        start_key;

    // Rising edge of key_ready; the edge register resets high so a key
    // held through reset cannot start a game.
    assign start_key = bus.key_ready & ~key_ready_d
                     & (bus.key_code == START_KEY);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_NEWGAME;
            timer_q     <= '0;
            balls_q     <= BALLS_INIT;
            score_q     <= '0;
            still_q     <= 1'b1;
            over_q      <= 1'b0;
            key_ready_d <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            balls_q     <= balls_d;
            score_q     <= score_d;
            still_q     <= still_d;
            over_q      <= over_d;
            key_ready_d <= bus.key_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        balls_d = balls_q;
        score_d = score_q;
        case (state_q)
            S_NEWGAME: begin
                if (start_key) begin
                    state_d = S_PLAY;
                    balls_d = BALLS_INIT;
                    score_d = '0;
                end
            end
            S_PLAY: begin
                if (bus.hit && score_q != 16'h9999)
                    score_d = bcd_inc(score_q);
                if (bus.miss) begin
                    timer_d = DELAY_INIT;
                    if (balls_q > 2'd1) begin
                        state_d = S_NEWBALL;
                        balls_d = balls_q - 2'd1;
                    end else begin
                        state_d = S_OVER;
                        balls_d = '0;
                    end
                end
            end
            S_NEWBALL: begin
                // Start looks at the timer before this edge's decrement.
                if (start_key && timer_q == 8'd0)
                    state_d = S_PLAY;
                if (bus.frame_tick && timer_q != 8'd0)
                    timer_d = timer_q - 8'd1;
            end
            S_OVER: begin
                if (timer_q == 8'd0)
                    state_d = S_NEWGAME;
                else if (bus.frame_tick)
                    timer_d = timer_q - 8'd1;
            end
            default: state_d = S_NEWGAME;
        endcase
    end

    // Flags are registered from the next state so they line up with it.
    always_comb begin
        still_d = (state_d != S_PLAY);
        over_d  = (state_d == S_OVER);
    end

    assign bus.state     = state_q;
    assign bus.gra_still = still_q;
    assign bus.balls     = balls_q;
    assign bus.score     = score_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl with a behavioural game model.
// Directed scenarios followed by a randomized phase.
module tb_breakout_game_ctrl;

    localparam int BALLS = 3;
    localparam int DELAY = 120;
    localparam int KSTART = 16;

    logic clk;
    logic reset;

    breakout_game_ctrl_if bif ();

    breakout_game_ctrl #(
        .BALLS(BALLS),
        .DELAY_FRAMES(DELAY),
        .START_KEY(5'h10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]  st;
        logic        still;
        logic [1:0]  balls;
        logic [15:0] score;
        logic        over;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t got;
    int   total = 0;
    int   bad = 0;

    // Model state: mode 0 newgame, 1 play, 2 newball, 3 over.
    int m_mode = 0;
    int m_balls = BALLS;
    int m_score = 0;
    int m_timer = 0;
    int m_kprev = 1;

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        r[15:12] = 4'((s / 1000) % 10);
        r[11:8]  = 4'((s / 100) % 10);
        r[7:4]   = 4'((s / 10) % 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    task automatic model(input bit rst, input bit ft, input bit kr,
                         input int kc, input bit h, input bit m);
        bit start;
        if (rst) begin
            m_mode  = 0;
            m_balls = BALLS;
            m_score = 0;
            m_timer = 0;
            m_kprev = 1;
        end else begin
            start = kr && (m_kprev == 0) && (kc == KSTART);
            if (m_mode == 0) begin
                if (start) begin
                    m_mode  = 1;
                    m_balls = BALLS;
                    m_score = 0;
                end
            end else if (m_mode == 1) begin
                if (h && m_score < 9999) m_score++;
                if (m) begin
                    m_timer = DELAY;
                    if (m_balls > 1) begin
                        m_balls--;
                        m_mode = 2;
                    end else begin
                        m_balls = 0;
                        m_mode  = 3;
                    end
                end
            end else if (m_mode == 2) begin
                if (start && m_timer == 0) m_mode = 1;
                if (ft && m_timer > 0) m_timer--;
            end else begin
                if (m_timer == 0) m_mode = 0;
                else if (ft) m_timer--;
            end
            m_kprev = kr ? 1 : 0;
        end
    endtask

    task automatic cyc(input bit rst, input bit ft, input bit kr,
                       input int kc, input bit h, input bit m);
        exp_t x;
        reset          = rst;
        bif.frame_tick = ft;
        bif.key_ready  = kr;
        bif.key_code   = 5'(kc);
        bif.hit        = h;
        bif.miss       = m;
        model(rst, ft, kr, kc, h, m);
        x.st    = 2'(m_mode);
        x.still = (m_mode != 1);
        x.balls = 2'(m_balls);
        x.score = to_bcd(m_score);
        x.over  = (m_mode == 3);
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press(input int code);
        cyc(0, 0, 1, code, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            got.st    = bif.state;
            got.still = bif.gra_still;
            got.balls = bif.balls;
            got.score = bif.score;
            got.over  = bif.game_over;
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got st=%0d still=%0b balls=%0d score=%h over=%0b exp st=%0d still=%0b balls=%0d score=%h over=%0b",
                         $time, got.st, got.still, got.balls, got.score,
                         got.over, e.st, e.still, e.balls, e.score, e.over);
            end
        end
    end

    initial begin
        bit rkr;
        int rkc;
        reset          = 1'b1;
        bif.frame_tick = 1'b0;
        bif.key_ready  = 1'b0;
        bif.key_code   = 5'h0;
        bif.hit        = 1'b0;
        bif.miss       = 1'b0;

        // Reset with the start key held: nothing may fire.
        cyc(1, 0, 1, KSTART, 0, 0);
        cyc(1, 0, 1, KSTART, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, KSTART, 0, 0);
        idle(2);

        // Start, wrong key, twelve hits.
        press(KSTART);
        press(12);
        hits(12);

        // Reach 0099, then hit and miss together.
        hits(87);
        cyc(0, 0, 0, 0, 1, 1);
        press(KSTART);
        ticks(3);
        for (int i = 0; i < DELAY - 4; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, KSTART, 0, 0);
        idle(1);
        press(KSTART);

        // Lose the remaining balls; over auto-returns to newgame.
        cyc(0, 0, 0, 0, 0, 1);
        ticks(DELAY);
        press(KSTART);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(DELAY);
        idle(3);

        // Fresh game: three misses down to over.
        press(KSTART);
        hits(5);
        for (int b = 0; b < 3; b++) begin
            cyc(0, 0, 0, 0, 0, 1);
            ticks(DELAY);
            press(KSTART);
        end
        idle(2);

        // Saturation at 9999, then hits ignored in newball.
        press(KSTART);
        hits(9998);
        hits(3);
        cyc(0, 0, 0, 0, 0, 1);
        hits(4);

        // Reset in the middle of the newball countdown.
        ticks(70);
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);
        press(KSTART);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(DELAY + 2);
        press(KSTART);

        // Randomized phase.
        rkr = 1'b0;
        rkc = KSTART;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) begin
                rkr = ~rkr;
                rkc = ($urandom_range(1) == 0) ? KSTART
                                               : int'($urandom_range(31));
            end
            cyc(($urandom_range(499) == 0),
                ($urandom_range(1) == 0),
                rkr, rkc,
                ($urandom_range(2) == 0),
                ($urandom_range(24) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
